// File: rtl/alu_chk_pkg.sv
// Shared opcode and FSM-state encodings for the ALU response checker.
package alu_chk_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: expected {c,y} for a given a, b, sel.
module alu_ref_model
  import alu_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] exp_y_c,
  output logic             exp_c_c
);

  logic [WIDTH:0] wide_c;

  always_comb begin
    wide_c  = '0;
    exp_y_c = '0;
    exp_c_c = 1'b0;
    case (sel)
      OP_ADD: begin
        wide_c  = {1'b0, a} + {1'b0, b};
        exp_y_c = wide_c[WIDTH-1:0];
        exp_c_c = wide_c[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow.
        wide_c  = {1'b0, a} - {1'b0, b};
        exp_y_c = wide_c[WIDTH-1:0];
        exp_c_c = wide_c[WIDTH];
      end
      OP_AND: exp_y_c = a & b;
      OP_OR:  exp_y_c = a | b;
      OP_XOR: exp_y_c = a ^ b;
      OP_NOT: exp_y_c = ~a;
      OP_SHL: begin
        exp_y_c = {a[WIDTH-2:0], 1'b0};
        exp_c_c = a[WIDTH-1];
      end
      default: begin
        exp_y_c = {1'b0, a[WIDTH-1:1]};
        exp_c_c = a[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: accepts observed vectors, compares to a reference model, reports pass/fail.
// Optional first-mismatch capture ports enabled by `ALU_ERR_CAPTURE_EN.
module alu_resp_checker
  import alu_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] y,
  input  logic             c,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
`ifdef ALU_ERR_CAPTURE_EN
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [2:0]       err_sel,
  output logic [WIDTH-1:0] err_y,
  output logic             err_c,
  output logic [WIDTH:0]   err_exp,
`endif
  output logic             done,
  output logic             pass
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_c_q, s1_c_d;
  logic [WIDTH-1:0] s1_exp_y_q, s1_exp_y_d;
  logic             s1_exp_c_q, s1_exp_c_d;

`ifdef ALU_ERR_CAPTURE_EN
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_sel_q, s1_sel_d;
  logic [WIDTH-1:0] err_a_q, err_a_d;
  logic [WIDTH-1:0] err_b_q, err_b_d;
  logic [2:0]       err_sel_q, err_sel_d;
  logic [WIDTH-1:0] err_y_q, err_y_d;
  logic             err_c_q, err_c_d;
  logic [WIDTH:0]   err_exp_q, err_exp_d;
`endif

  logic [WIDTH-1:0] exp_y_c;
  logic             exp_c_c;
  logic             xfer_c;
  logic             mismatch_c;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a       (a),
    .b       (b),
    .sel     (sel),
    .exp_y_c (exp_y_c),
    .exp_c_c (exp_c_c)
  );

  // Next-state: stage1 capture, stage2 compare/count, then FSM (start clears win).
  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    acc_d      = acc_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    s1_y_d     = s1_y_q;
    s1_c_d     = s1_c_q;
    s1_exp_y_d = s1_exp_y_q;
    s1_exp_c_d = s1_exp_c_q;
`ifdef ALU_ERR_CAPTURE_EN
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    err_a_d    = err_a_q;
    err_b_d    = err_b_q;
    err_sel_d  = err_sel_q;
    err_y_d    = err_y_q;
    err_c_d    = err_c_q;
    err_exp_d  = err_exp_q;
`endif

    xfer_c     = in_valid && in_ready_q;
    s1_valid_d = xfer_c;
    if (xfer_c) begin
      s1_y_d     = y;
      s1_c_d     = c;
      s1_exp_y_d = exp_y_c;
      s1_exp_c_d = exp_c_c;
`ifdef ALU_ERR_CAPTURE_EN
      s1_a_d     = a;
      s1_b_d     = b;
      s1_sel_d   = sel;
`endif
    end
    acc_d = acc_q + CNT_W'(xfer_c);

    mismatch_c = s1_valid_q && ({s1_c_q, s1_y_q} != {s1_exp_c_q, s1_exp_y_q});
    if (s1_valid_q) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
    end
    if (mismatch_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
`ifdef ALU_ERR_CAPTURE_EN
    // err_cnt never returns to zero within a run, so zero marks the first mismatch.
    if (mismatch_c && (err_cnt_q == '0)) begin
      err_a_d   = s1_a_q;
      err_b_d   = s1_b_q;
      err_sel_d = s1_sel_q;
      err_y_d   = s1_y_q;
      err_c_d   = s1_c_q;
      err_exp_d = {s1_exp_c_q, s1_exp_y_q};
    end
`endif

    case (state_q)
      ST_RUN: begin
        if (acc_d == num_vec_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0);
        end
      end
      default: begin
        if (start) begin
          state_d   = (num_vec == '0) ? ST_DRAIN : ST_RUN;
          num_vec_d = num_vec;
          acc_d     = '0;
          vec_cnt_d = '0;
          err_cnt_d = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
`ifdef ALU_ERR_CAPTURE_EN
          err_a_d   = '0;
          err_b_d   = '0;
          err_sel_d = '0;
          err_y_d   = '0;
          err_c_d   = 1'b0;
          err_exp_d = '0;
`endif
        end
      end
    endcase

    in_ready_d = (state_d == ST_RUN) && (acc_d < num_vec_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_vec_q  <= '0;
      acc_q      <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_c_q     <= 1'b0;
      s1_exp_y_q <= '0;
      s1_exp_c_q <= 1'b0;
`ifdef ALU_ERR_CAPTURE_EN
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= '0;
      err_a_q    <= '0;
      err_b_q    <= '0;
      err_sel_q  <= '0;
      err_y_q    <= '0;
      err_c_q    <= 1'b0;
      err_exp_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      acc_q      <= acc_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_c_q     <= s1_c_d;
      s1_exp_y_q <= s1_exp_y_d;
      s1_exp_c_q <= s1_exp_c_d;
`ifdef ALU_ERR_CAPTURE_EN
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      err_sel_q  <= err_sel_d;
      err_y_q    <= err_y_d;
      err_c_q    <= err_c_d;
      err_exp_q  <= err_exp_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign done     = done_q;
  assign pass     = pass_q;
`ifdef ALU_ERR_CAPTURE_EN
  assign err_a    = err_a_q;
  assign err_b    = err_b_q;
  assign err_sel  = err_sel_q;
  assign err_y    = err_y_q;
  assign err_c    = err_c_q;
  assign err_exp  = err_exp_q;
`endif

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker (WIDTH=4); capture checks active with `ALU_ERR_CAPTURE_EN.
module tb_alu_resp_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, y;
  logic [2:0]       sel;
  logic             c;
  logic [CNT_W-1:0] vec_cnt, err_cnt;
  logic             done, pass;
`ifdef ALU_ERR_CAPTURE_EN
  logic [WIDTH-1:0] err_a, err_b, err_y;
  logic [2:0]       err_sel;
  logic             err_c;
  logic [WIDTH:0]   err_exp;
`endif

  int checks   = 0;
  int failures = 0;
  int xfers;

  always #5 clk = ~clk;

  alu_resp_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_vec  (num_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .y        (y),
    .c        (c),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt),
`ifdef ALU_ERR_CAPTURE_EN
    .err_a    (err_a),
    .err_b    (err_b),
    .err_sel  (err_sel),
    .err_y    (err_y),
    .err_c    (err_c),
    .err_exp  (err_exp),
`endif
    .done     (done),
    .pass     (pass)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vec(input logic [2:0] s, input logic [3:0] va, input logic [3:0] vb,
                     input logic [3:0] vy, input logic vc);
    in_valid = 1'b1;
    sel = s; a = va; b = vb; y = vy; c = vc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    a = '0; b = '0; sel = '0; y = '0; c = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_vec_cnt",  32'(vec_cnt),  32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_pass",     32'(pass),     32'd0);

    // 1: three correct vectors
    start = 1'b1; num_vec = 16'd3;
    step();
    start = 1'b0;
    chk("t1_ready", 32'(in_ready), 32'd1);
    vec(3'b000, 4'd1, 4'd2, 4'b0011, 1'b0);   step();
    vec(3'b000, 4'd9, 4'd10, 4'b0011, 1'b1);  step();
    vec(3'b010, 4'hF, 4'hF, 4'hF, 1'b0);      step();
    in_valid = 1'b0;
    chk("t1_ready_drop", 32'(in_ready), 32'd0);
    chk("t1_vec_mid",    32'(vec_cnt),  32'd2);
    wait_done("t1_done");
    chk("t1_vec_cnt", 32'(vec_cnt), 32'd3);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_pass",    32'(pass),    32'd1);

    // 2: subtract with wrong borrow
    start = 1'b1; num_vec = 16'd1;
    step();
    start = 1'b0;
    chk("t2_cleared_done", 32'(done), 32'd0);
    vec(3'b001, 4'b1001, 4'b1010, 4'b1111, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t2_err_1cyc", 32'(err_cnt), 32'd0);
    step();
    chk("t2_err_2cyc", 32'(err_cnt), 32'd1);
    wait_done("t2_done");
    chk("t2_pass", 32'(pass), 32'd0);
`ifdef ALU_ERR_CAPTURE_EN
    chk("t2_err_sel", 32'(err_sel), 32'd1);
    chk("t2_err_exp", 32'(err_exp), 32'h1F);
    chk("t2_err_a",   32'(err_a),   32'h9);
    chk("t2_err_b",   32'(err_b),   32'hA);
    chk("t2_err_y",   32'(err_y),   32'hF);
    chk("t2_err_c",   32'(err_c),   32'd0);
`endif

    // 3: empty run, in_valid high must not transfer
    vec(3'b000, 4'd1, 4'd1, 4'd2, 1'b0);
    start = 1'b1; num_vec = 16'd0;
    step();
    start = 1'b0;
    chk("t3_ready0", 32'(in_ready), 32'd0);
    chk("t3_done0",  32'(done),     32'd0);
    step();
    chk("t3_done",    32'(done),    32'd1);
    chk("t3_pass",    32'(pass),    32'd1);
    chk("t3_ready1",  32'(in_ready), 32'd0);
    chk("t3_vec_cnt", 32'(vec_cnt), 32'd0);
    in_valid = 1'b0;

    // 4: in_valid held 5 cycles, only 4 accepted
    start = 1'b1; num_vec = 16'd4;
    step();
    start = 1'b0;
    xfers = 0;
    vec(3'b000, 4'd3, 4'd4, 4'd7, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (in_valid && in_ready) xfers++;
      step();
    end
    in_valid = 1'b0;
    chk("t4_xfers",     32'(xfers),    32'd4);
    chk("t4_ready_low", 32'(in_ready), 32'd0);
    chk("t4_done_early", 32'(done),    32'd0);
    step();
    chk("t4_done",    32'(done),    32'd1);
    chk("t4_vec_cnt", 32'(vec_cnt), 32'd4);
    chk("t4_pass",    32'(pass),    32'd1);

    // 5: reset with vectors in flight
    start = 1'b1; num_vec = 16'd5;
    step();
    start = 1'b0;
    vec(3'b100, 4'b1010, 4'b0101, 4'b0000, 1'b0); step();
    vec(3'b100, 4'b1010, 4'b0101, 4'b1111, 1'b0); step();
    chk("t5_err_pre", 32'(err_cnt), 32'd1);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_vec_cnt",  32'(vec_cnt),  32'd0);
    chk("t5_err_cnt",  32'(err_cnt),  32'd0);
    chk("t5_done",     32'(done),     32'd0);
    chk("t5_pass",     32'(pass),     32'd0);
    step();
    chk("t5_vec_hold", 32'(vec_cnt), 32'd0);
    start = 1'b1; num_vec = 16'd2;
    step();
    start = 1'b0;
    vec(3'b100, 4'b1010, 4'b0101, 4'b1111, 1'b0); step();
    vec(3'b110, 4'b1001, 4'd0, 4'b0010, 1'b1);    step();
    in_valid = 1'b0;
    wait_done("t5_done2");
    chk("t5_vec2",  32'(vec_cnt), 32'd2);
    chk("t5_err2",  32'(err_cnt), 32'd0);
    chk("t5_pass2", 32'(pass),    32'd1);

    // 6: start ignored in RUN, honoured in DONE
    start = 1'b1; num_vec = 16'd3;
    step();
    start = 1'b0;
    vec(3'b011, 4'b0101, 4'b0011, 4'b0111, 1'b0); step();
    start = 1'b1; num_vec = 16'd1;
    vec(3'b101, 4'b0101, 4'd0, 4'b1010, 1'b0);    step();
    start = 1'b0;
    vec(3'b111, 4'b0111, 4'd0, 4'b0011, 1'b1);    step();
    in_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_vec_cnt", 32'(vec_cnt), 32'd3);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_pass",    32'(pass),    32'd1);
    start = 1'b1; num_vec = 16'd1;
    step();
    start = 1'b0;
    chk("t6_restart_vec",   32'(vec_cnt),  32'd0);
    chk("t6_restart_done",  32'(done),     32'd0);
    chk("t6_restart_ready", 32'(in_ready), 32'd1);
    vec(3'b001, 4'd3, 4'd5, 4'b1110, 1'b1); step();
    in_valid = 1'b0;
    wait_done("t6_done2");
    chk("t6_vec2",  32'(vec_cnt), 32'd1);
    chk("t6_pass2", 32'(pass),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
